// File: rtl/down_cntr_timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : down_cntr_timer_pkg                                        |
// | Description : Shared definitions for the down-counter/timer: FSM state   |
// |               encodings and a ceil-log2 helper for sizing the prescaler. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package down_cntr_timer_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage : down_cntr_timer_pkg
`default_nettype wire

// File: rtl/down_cntr_timer_presc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cntr_presc                                                 |
// | Description : Tick prescaler. Emits one tick every PRESC enabled cycles  |
// |               while run is high. With PRESC=1 it degenerates to run&en.  |
// | Ports       : clk, reset  - clock / synchronous active-high reset        |
// |               clr         - clear the phase counter                      |
// |               run         - counting allowed this cycle                  |
// |               en          - tick enable (low freezes the phase)          |
// |               tick        - combinational tick strobe                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cntr_presc
    import down_cntr_timer_pkg::*;
#(
    parameter int PRESC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    input  logic en,
    output logic tick
);

    generate
        if (PRESC == 1) begin : g_presc_bypass
            // No phase state needed; clock/reset/clr are intentionally unused.
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset, clr};
            assign tick     = run & en;
        end else begin : g_presc_cnt
            localparam int         c_w    = clog2(PRESC);
            localparam logic [c_w-1:0] c_last = c_w'(PRESC - 1);

            logic [c_w-1:0] r_phase;

            always_ff @(posedge clk) begin
                if (reset || clr) begin
                    r_phase <= '0;
                end else if (run && en) begin
                    if (r_phase == c_last) begin
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + c_w'(1);
                    end
                end
            end

            assign tick = run & en & (r_phase == c_last);
        end
    endgenerate

endmodule : cntr_presc
`default_nettype wire

// File: rtl/down_cntr_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : down_cntr_timer                                            |
// | Description : Programmable N-bit down-counter/timer with pause/resume,   |
// |               one-shot or auto-reload modes and a tick prescaler.        |
// |               Emits a one-cycle registered tc pulse on expiry.           |
// | Ports       : clk, reset   - clock / synchronous active-high reset       |
// |               en           - tick enable                                 |
// |               load/load_val- load count and reload register              |
// |               start/stop   - begin-resume / pause counting               |
// |               auto_reload  - 1: reload at expiry, 0: one-shot            |
// |               cnt_out      - current count (registered)                  |
// |               tc           - terminal-count pulse (registered)           |
// |               busy / done  - in RUN / in DONE (registered)               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module down_cntr_timer
    import down_cntr_timer_pkg::*;
#(
    parameter int N     = 8,
    parameter int PRESC = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         stop,
    input  logic         auto_reload,
    output logic [N-1:0] cnt_out,
    output logic         tc,
    output logic         busy,
    output logic         done
);

    logic [1:0]   r_state;
    logic [N-1:0] r_cnt;
    logic [N-1:0] r_reload;
    logic         r_tc;
    logic         r_busy;
    logic         r_done;

    logic [1:0]   w_state_nxt;
    logic [N-1:0] w_cnt_nxt;
    logic [N-1:0] w_reload_nxt;
    logic         w_tc_nxt;
    logic         w_presc_clr;
    logic         w_presc_run;
    logic         w_tick;

    // load and stop both outrank the tick, so the prescaler must not advance
    // in a cycle where either takes effect (stop only matters in RUN).
    assign w_presc_run = (r_state == ST_RUN) & ~load & ~stop;

    cntr_presc #(
        .PRESC (PRESC)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .clr   (w_presc_clr),
        .run   (w_presc_run),
        .en    (en),
        .tick  (w_tick)
    );

    // Next-state logic in priority order: load > stop > start > tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        w_presc_clr  = 1'b0;

        if (load) begin
            w_cnt_nxt    = load_val;
            w_reload_nxt = load_val;
            w_state_nxt  = ST_IDLE;
            w_presc_clr  = 1'b1;
        end else if (stop && (r_state == ST_RUN)) begin
            w_state_nxt = ST_IDLE;
        end else if (start && !stop && (r_state == ST_IDLE)) begin
            w_state_nxt = ST_RUN;
        end else if (start && !stop && (r_state == ST_DONE)) begin
            w_cnt_nxt   = r_reload;
            w_state_nxt = ST_RUN;
            w_presc_clr = 1'b1;
        end else if (w_tick) begin
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - N'(1);
            end else begin
                // Zero is the expiry point, so the decrement never wraps.
                w_tc_nxt = 1'b1;
                if (auto_reload) begin
                    w_cnt_nxt = r_reload;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
            r_busy   <= (w_state_nxt == ST_RUN);
            r_done   <= (w_state_nxt == ST_DONE);
        end
    end

    assign cnt_out = r_cnt;
    assign tc      = r_tc;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule : down_cntr_timer
`default_nettype wire

// File: tb/tb_down_cntr_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_down_cntr_timer                                         |
// | Description : Self-checking bench for down_cntr_timer. Two instances     |
// |               (PRESC=1 and PRESC=4) share stimulus; both are compared    |
// |               against a behavioural model every cycle, with directed     |
// |               scenarios followed by randomized traffic.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_down_cntr_timer;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic         en;
    logic         load;
    logic [N-1:0] load_val;
    logic         start;
    logic         stop;
    logic         auto_reload;

    logic [N-1:0] a_cnt, b_cnt;
    logic         a_tc, b_tc, a_busy, b_busy, a_done, b_done;

    int n_checks = 0;
    int n_pass   = 0;

    down_cntr_timer #(.N(N), .PRESC(1)) u_dut_a (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .auto_reload(auto_reload),
        .cnt_out(a_cnt), .tc(a_tc), .busy(a_busy), .done(a_done)
    );

    down_cntr_timer #(.N(N), .PRESC(4)) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .auto_reload(auto_reload),
        .cnt_out(b_cnt), .tc(b_tc), .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model (index 0: PRESC=1, 1: PRESC=4) -----
    localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;
    int m_presc [2] = '{1, 4};
    int m_cnt   [2];
    int m_rel   [2];
    int m_st    [2];
    int m_pc    [2];
    int m_tc    [2];

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_tc[i] = 0;
            if (reset) begin
                m_cnt[i] = 0; m_rel[i] = 0; m_st[i] = S_IDLE; m_pc[i] = 0;
            end else if (load) begin
                m_cnt[i] = int'(load_val); m_rel[i] = int'(load_val);
                m_st[i] = S_IDLE; m_pc[i] = 0;
            end else if (stop && m_st[i] == S_RUN) begin
                m_st[i] = S_IDLE;
            end else if (start && !stop && m_st[i] != S_RUN) begin
                if (m_st[i] == S_DONE) begin
                    m_cnt[i] = m_rel[i];
                    m_pc[i]  = 0;
                end
                m_st[i] = S_RUN;
            end else if (m_st[i] == S_RUN && en) begin
                if (m_pc[i] == m_presc[i] - 1) begin
                    m_pc[i] = 0;
                    if (m_cnt[i] > 0) begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end else begin
                        m_tc[i] = 1;
                        if (auto_reload) m_cnt[i] = m_rel[i];
                        else             m_st[i]  = S_DONE;
                    end
                end else begin
                    m_pc[i] = m_pc[i] + 1;
                end
            end
        end
    endtask

    // ---------------- checking ----------------------------------------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic compare_all();
        check("a_cnt",  32'(a_cnt),  32'(m_cnt[0]));
        check("a_tc",   32'(a_tc),   32'(m_tc[0]));
        check("a_busy", 32'(a_busy), 32'(m_st[0] == S_RUN));
        check("a_done", 32'(a_done), 32'(m_st[0] == S_DONE));
        check("b_cnt",  32'(b_cnt),  32'(m_cnt[1]));
        check("b_tc",   32'(b_tc),   32'(m_tc[1]));
        check("b_busy", 32'(b_busy), 32'(m_st[1] == S_RUN));
        check("b_done", 32'(b_done), 32'(m_st[1] == S_DONE));
    endtask

    // One clock: model follows the inputs sampled at the edge, outputs are
    // checked 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic ld, input logic [N-1:0] lv, input logic st,
                         input logic sp, input logic e, input logic ar);
        load = ld; load_val = lv; start = st; stop = sp; en = e; auto_reload = ar;
    endtask

    int n;
    int pulses;

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_st[i] = S_IDLE; m_pc[i] = 0; m_tc[i] = 0;
        end
        cycle(); cycle();
        check("reset_cnt", 32'(a_cnt), 0);
        check("reset_flags", 32'({a_tc, a_busy, a_done}), 0);
        reset = 1'b0;

        // One-shot latency, V=3
        drive(1, 8'd3, 0, 0, 1, 0); cycle();
        check("oneshot_load", 32'(a_cnt), 3);
        drive(0, 0, 1, 0, 1, 0); cycle();
        check("oneshot_busy", 32'(a_busy), 1);
        drive(0, 0, 0, 0, 1, 0);
        cycle(); check("oneshot_c2", 32'(a_cnt), 2);
        cycle(); check("oneshot_c1", 32'(a_cnt), 1);
        cycle(); check("oneshot_c0", 32'(a_cnt), 0);
        check("oneshot_no_tc", 32'(a_tc), 0);
        cycle(); check("oneshot_tc", 32'(a_tc), 1);
        check("oneshot_done", 32'({a_done, a_busy}), 32'b10);
        cycle(); check("oneshot_tc_1cyc", 32'(a_tc), 0);
        check("oneshot_hold0", 32'(a_cnt), 0);

        // Start from DONE reloads the reload register
        drive(0, 0, 1, 0, 1, 0); cycle();
        check("restart_reload", 32'(a_cnt), 3);

        // Reset mid-RUN: aborted, no tc afterwards
        drive(0, 0, 0, 0, 1, 0); cycle();
        reset = 1'b1; cycle(); cycle(); reset = 1'b0;
        check("midrun_reset", 32'({a_cnt, a_tc, a_busy, a_done}), 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin cycle(); pulses += int'(a_tc); end
        check("no_tc_after_reset", 32'(pulses), 0);

        // Auto-reload, V=2: 12 ticks give 4 pulses
        drive(1, 8'd2, 0, 0, 1, 1); cycle();
        drive(0, 0, 1, 0, 1, 1); cycle();
        drive(0, 0, 0, 0, 1, 1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin cycle(); pulses += int'(a_tc); end
        check("autoreload_pulses", 32'(pulses), 4);

        // Pause/resume with en low
        drive(1, 8'd10, 0, 0, 1, 0); cycle();
        drive(0, 0, 1, 0, 1, 0); cycle();
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle();
        drive(0, 0, 0, 1, 1, 0); cycle();
        drive(0, 0, 0, 0, 1, 0); cycle();
        check("pause_hold", 32'(a_cnt), 6);
        check("pause_busy", 32'(a_busy), 0);
        drive(0, 0, 1, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle();
        check("en_low_frozen", 32'(a_cnt), 6);
        check("en_low_busy", 32'(a_busy), 1);
        drive(0, 0, 0, 0, 1, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(); n++;
            if (a_tc) break;
        end
        check("resume_ticks", 32'(n), 7);

        // Collisions
        drive(1, 8'd5, 1, 0, 1, 0); cycle();
        drive(0, 0, 0, 0, 1, 0); cycle();
        check("load_start_idle", 32'({a_busy, a_cnt}), 5);
        drive(0, 0, 1, 1, 1, 0); cycle();
        check("start_stop_idle", 32'(a_busy), 0);
        drive(1, 8'd0, 0, 0, 1, 0); cycle();
        drive(0, 0, 1, 0, 1, 0); cycle();
        drive(1, 8'd9, 0, 0, 1, 0); cycle();
        check("load_on_expiry_tc", 32'(a_tc), 0);
        check("load_on_expiry_cnt", 32'(a_cnt), 9);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            reset       = ($urandom_range(0, 199) == 0);
            load        = ($urandom_range(0, 29) == 0);
            load_val    = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 6));
            start       = ($urandom_range(0, 7) == 0);
            stop        = ($urandom_range(0, 24) == 0);
            en          = ($urandom_range(0, 9) != 0);
            auto_reload = $urandom_range(0, 1) == 1;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_down_cntr_timer
`default_nettype wire
